// File: rtl/approx_serial_subtractor.sv
// Bit-serial approximate subtractor: Diff = A - B - Bin, LSB first, one bit per clock.
// Low APPROX_K cells drop the incoming borrow; optional error monitor under APPROX_SUB_ERR_MON_EN.
module approx_serial_subtractor #(
    parameter int unsigned N        = 8,
    parameter int unsigned APPROX_K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Diff,
    output logic         Bout
`ifdef APPROX_SUB_ERR_MON_EN
    ,
    output logic [N:0]   err_dist,
    output logic         err_flag
`endif
);

    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    // Bit i uses the approximate cell when ApproxMask[i] is set.
    localparam logic [N-1:0] ApproxMask = ~({N{1'b1}} << APPROX_K);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic            borrow_q, borrow_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    diff_q, diff_d;
    logic            bout_q, bout_d;

    logic cell_a, cell_b, cell_d, cell_gen, cell_prop, cell_borrow;

`ifdef APPROX_SUB_ERR_MON_EN
    logic [N-1:0] op_a_q, op_a_d;
    logic [N-1:0] op_b_q, op_b_d;
    logic         op_bin_q, op_bin_d;
    logic [N:0]   err_dist_q, err_dist_d;
    logic [N:0]   exact_full, approx_full, err_raw, err_abs;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef APPROX_SUB_ERR_MON_EN
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_bin_q   <= 1'b0;
            err_dist_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
`ifdef APPROX_SUB_ERR_MON_EN
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_bin_q   <= op_bin_d;
            err_dist_q <= err_dist_d;
`endif
        end
    end

    // Single full-subtractor cell operating on the current LSBs.
    always_comb begin
        cell_a      = a_q[0];
        cell_b      = b_q[0];
        cell_d      = cell_a ^ cell_b ^ borrow_q;
        cell_gen    = ~cell_a & cell_b;
        cell_prop   = ~(cell_a ^ cell_b) & borrow_q;
        cell_borrow = ApproxMask[cnt_q] ? cell_gen : (cell_gen | cell_prop);
    end

`ifdef APPROX_SUB_ERR_MON_EN
    always_comb begin
        exact_full  = {1'b0, op_a_q} - {1'b0, op_b_q} - {{N{1'b0}}, op_bin_q};
        approx_full = {cell_borrow, cell_d, a_q[N-1:1]};
        err_raw     = approx_full - exact_full;
        err_abs     = err_raw[N] ? (~err_raw + (N+1)'(1)) : err_raw;
    end
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
`ifdef APPROX_SUB_ERR_MON_EN
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_bin_d   = op_bin_q;
        err_dist_d = err_dist_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = Bin;
                    cnt_d    = '0;
                    state_d  = StRun;
`ifdef APPROX_SUB_ERR_MON_EN
                    op_a_d   = A;
                    op_b_d   = B;
                    op_bin_d = Bin;
`endif
                end
            end
            StRun: begin
                // Result bits enter the minuend register from the top as its LSBs retire,
                // so after N shifts it holds the full difference.
                a_d      = {cell_d, a_q[N-1:1]};
                b_d      = {1'b0, b_q[N-1:1]};
                borrow_d = cell_borrow;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(N - 1)) begin
                    diff_d  = {cell_d, a_q[N-1:1]};
                    bout_d  = cell_borrow;
                    state_d = StDone;
`ifdef APPROX_SUB_ERR_MON_EN
                    err_dist_d = err_abs;
`endif
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        Diff      = diff_q;
        Bout      = bout_q;
`ifdef APPROX_SUB_ERR_MON_EN
        err_dist  = err_dist_q;
        err_flag  = |err_dist_q;
`endif
    end

endmodule
